mem_arbiter: RTL and testbench

Shares one fixed-latency, single-ported RAM between the datapath's instruction-fetch port and its data port. It sits between the datapath, which drives the fetch and data enables produced by the control unit, and the RAM model. Arbitration, access sequencing and wait-state generation are handled by a small FSM with a latency counter. A sticky halt latch stops instruction fetches once the core halts, so memory traffic quiesces cleanly.

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-ported RAM between fetch and data ports.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined (fixed data priority otherwise).
module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        halt,
    output logic        halted,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   acc_addr, acc_store;
    logic          acc_wr, dreq, ireq, grant_d, grant_i, busy, done;

    assign dreq = dREN | dWEN;
    assign ireq = iREN & ~halted;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    always_ff @(posedge CLK) begin
        if (RST)
            last_d <= 1'b0;
        else if (state == IDLE && (grant_d || grant_i))
            last_d <= grant_d;
    end
    assign grant_i = ireq & (~dreq | last_d);
`else
    assign grant_i = ireq & ~dreq;
`endif
    assign grant_d = dreq & ~grant_i;

    assign busy = state != IDLE;
    assign done = cnt == '0;

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = grant_d ? DACC : grant_i ? IACC : IDLE;
        else if (done)
            state_n = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            halted    <= 1'b0;
            acc_addr  <= '0;
            acc_store <= '0;
            acc_wr    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (halt && !dreq)
                    halted <= 1'b1;
                if (grant_d || grant_i) begin
                    cnt       <= CW'(LATENCY - 1);
                    acc_addr  <= grant_d ? daddr : iaddr;
                    acc_store <= dstore;
                    acc_wr    <= grant_d & dWEN;
                end
            end else if (!done) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // RAM side is driven only from the registered copies so it stays stable per access
    assign ramREN   = busy & ~acc_wr;
    assign ramWEN   = busy & acc_wr;
    assign ramaddr  = busy ? acc_addr : '0;
    assign ramstore = busy ? acc_store : '0;

    assign iwait = iREN & ~(state == IACC & done);
    assign dwait = dreq & ~(state == DACC & done);
    assign iload = ramload;
    assign dload = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single accesses with a load scoreboard, plus hand sequences
// for arbitration, halt, and mid-access reset (second instance with LATENCY=3).
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic        CLK, RST, iREN, iwait, dREN, dWEN, dwait, halt, halted, ramREN, ramWEN;
    logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    logic        r_RST, r_iREN, r_iwait, r_dREN, r_dWEN, r_dwait, r_halt, r_halted, r_ramREN, r_ramWEN;
    logic [31:0] r_iaddr, r_iload, r_daddr, r_dstore, r_dload, r_ramaddr, r_ramstore, r_ramload;

    mem_arbiter #(.LATENCY(LAT)) u0 (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .halt(halt), .halted(halted), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload)
    );

    mem_arbiter #(.LATENCY(3)) u1 (
        .CLK(CLK), .RST(r_RST), .iREN(r_iREN), .iaddr(r_iaddr), .iwait(r_iwait), .iload(r_iload),
        .dREN(r_dREN), .dWEN(r_dWEN), .daddr(r_daddr), .dstore(r_dstore), .dwait(r_dwait),
        .dload(r_dload), .halt(r_halt), .halted(r_halted), .ramREN(r_ramREN), .ramWEN(r_ramWEN),
        .ramaddr(r_ramaddr), .ramstore(r_ramstore), .ramload(r_ramload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        logic [65:0] strobes;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        int          lat;
    } exp_t;

    vec_t vt[5];
    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic got, w;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for wait to drop", name);
    endtask

    function automatic logic [65:0] strb();
        return {ramREN, ramWEN, ramaddr, ramstore};
    endfunction

    function automatic logic [65:0] r_strb();
        return {r_ramREN, r_ramWEN, r_ramaddr, r_ramstore};
    endfunction

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, {1'b1, 1'b0, 32'h40, 32'h0}};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h55, 32'hCAFEF00D, {1'b1, 1'b0, 32'h100, 32'h55}};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h80, 32'h1234, 32'h0000A5A5, {1'b0, 1'b1, 32'h80, 32'h1234}};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h200, 32'hFFFF0000, 32'h11112222, {1'b0, 1'b1, 32'h200, 32'hFFFF0000}};
        vt[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h13579BDF, {1'b1, 1'b0, 32'hFFFFFFFC, 32'h0}};

        RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0; halt = 0; ramload = 0;
        r_RST = 1; r_iREN = 0; r_iaddr = 0; r_dREN = 0; r_dWEN = 0; r_daddr = 0; r_dstore = 0;
        r_halt = 0; r_ramload = 0;

        @(negedge CLK); #1;
        chk("rst_strobes", strb(), 66'd0);
        chk("rst_waits_idle", {iwait, dwait}, 2'b00);
        chk("rst_halted", halted, 0);
        @(negedge CLK);
        iREN = 1; dWEN = 1;
        #1;
        chk("rst_waits_follow", {iwait, dwait}, 2'b11);
        chk("rst_strobes2", strb(), 66'd0);
        iREN = 0; dWEN = 0;
        r_RST = 0;

        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            RST = 0;
            iREN = !vt[n].is_d & vt[n].ren;
            iaddr = vt[n].is_d ? 32'h0 : vt[n].addr;
            dREN = vt[n].is_d & vt[n].ren;
            dWEN = vt[n].is_d & vt[n].wen;
            daddr = vt[n].is_d ? vt[n].addr : 32'h0;
            dstore = vt[n].store;
            ramload = vt[n].rdata;
            #1;
            chk("idle_strobes", strb(), 66'd0);
            chk("idle_waits", {iwait, dwait}, {!vt[n].is_d, vt[n].is_d});
            sb.push_back('{vt[n].rdata, LAT});
            got = 0;
            for (int c = 1; c <= 10 && !got; c++) begin
                @(negedge CLK); #1;
                w = vt[n].is_d ? dwait : iwait;
                chk("acc_strobes", strb(), vt[n].strobes);
                if (!w) begin
                    got = 1;
                    e = sb.pop_front();
                    chk("load", vt[n].is_d ? dload : iload, e.load);
                    chk("latency", 66'(c), 66'(e.lat));
                end
            end
            if (!got) timeout("vec_access");
            @(negedge CLK);
            iREN = 0; dREN = 0; dWEN = 0;
            #1;
            chk("post_idle_strobes", strb(), 66'd0);
        end
        chk("sb_empty", 66'(sb.size()), 66'd0);

        // both ports request together: data first, fetch after one idle cycle
        @(negedge CLK);
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramload = 32'h77;
        #1;
        chk("both_idle_waits", {iwait, dwait}, 2'b11);
        @(negedge CLK); #1;
        chk("both_dacc_strobes", strb(), {1'b0, 1'b1, 32'h80, 32'h1234});
        chk("both_dacc_iwait", iwait, 1);
        @(negedge CLK); #1;
        chk("both_dacc_done", {iwait, dwait}, 2'b10);
        @(negedge CLK);
        dWEN = 0;
        #1;
        chk("both_gap_strobes", strb(), 66'd0);
        chk("both_gap_iwait", iwait, 1);
        @(negedge CLK); #1;
        chk("both_iacc_strobes", {ramREN, ramWEN, ramaddr}, {1'b1, 1'b0, 32'h44});
        chk("both_iacc_iwait", iwait, 1);
        @(negedge CLK); #1;
        chk("both_iacc_done", iwait, 0);
        chk("both_iacc_load", iload, 32'h77);
        @(negedge CLK);
        iREN = 0;
        #1;
        chk("both_end_strobes", strb(), 66'd0);

        // halt in idle with fetch held high
        @(negedge CLK);
        iREN = 1; iaddr = 32'h48; halt = 1;
        #1;
        chk("halt_pre", halted, 0);
        @(negedge CLK);
        halt = 0;
        #1;
        chk("halt_set", halted, 1);
        got = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            if (!ramREN) got = 1;
            else begin @(negedge CLK); #1; end
        end
        if (!got) timeout("halt_drain");
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK); #1;
            chk("halt_quiet", {ramREN, ramWEN, iwait, halted}, 4'b0011);
        end
        @(negedge CLK);
        dREN = 1; daddr = 32'h300; ramload = 32'h0BADF00D;
        #1;
        got = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge CLK); #1;
            if (!dwait) begin
                got = 1;
                chk("halt_data_load", dload, 32'h0BADF00D);
                chk("halt_data_addr", {ramREN, ramaddr}, {1'b1, 32'h300});
                chk("halt_data_lat", 66'(c), 66'(LAT));
            end
        end
        if (!got) timeout("halt_data");
        @(negedge CLK);
        dREN = 0; iREN = 0;
        #1;
        chk("halt_sticky", halted, 1);

        // LATENCY=3 instance: reset during second DACC cycle abandons the access
        @(negedge CLK);
        r_dWEN = 1; r_daddr = 32'h500; r_dstore = 32'h77;
        #1;
        chk("r_idle_dwait", r_dwait, 1);
        @(negedge CLK); #1;
        chk("r_acc1_strobes", r_strb(), {1'b0, 1'b1, 32'h500, 32'h77});
        chk("r_acc1_dwait", r_dwait, 1);
        @(negedge CLK);
        r_RST = 1;
        #1;
        chk("r_acc2_strobes", r_strb(), {1'b0, 1'b1, 32'h500, 32'h77});
        chk("r_acc2_dwait", r_dwait, 1);
        @(negedge CLK); #1;
        chk("r_post_rst_strobes", r_strb(), 66'd0);
        chk("r_post_rst_dwait", r_dwait, 1);
        r_RST = 0; r_dWEN = 0; r_dREN = 1; r_daddr = 32'h600; r_ramload = 32'h600DCAFE;
        got = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge CLK); #1;
            chk("r_rd_strobes", {r_ramREN, r_ramWEN, r_ramaddr}, {1'b1, 1'b0, 32'h600});
            if (!r_dwait) begin
                got = 1;
                chk("r_rd_load", r_dload, 32'h600DCAFE);
                chk("r_rd_lat", 66'(c), 66'd3);
            end
        end
        if (!got) timeout("r_read");
        @(negedge CLK);
        r_dREN = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
